bypass_source: RTL and testbench
================================

# bypass_source

Producer side of the execute-stage forwarding interface. Registers both issue slots' ALU results and destination info through the LSU and WB pipeline stages. Drives the write-valid, address and data buses that the execute-stage bypass network consumes (wm/am/bypass_lsu, ww/aw/bypass_wb), and the register-file write port. Also detects load-use hazards for the decode stage, since LSU-stage load results cannot be forwarded.

## Interface
No parameters. Slot k is 0 or 1; slot 1 is always the younger instruction of the pair.

- clk_i  in  1  core clock; all state updates on its rising edge
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  hold LSU and WB stage registers
- flush_i  in  1  squash the pair leaving EX (LSU capture loads zeros)
- exk_rd_we_i  in  1  slot k EX instruction writes rd
- exk_rd_i  in  5  slot k EX destination address
- exk_is_load_i  in  1  slot k EX instruction is a load
- aluk_i  in  32  slot k ALU result
- lsu_rdatak_i  in  32  slot k load data, valid during LSU stage
- idk_rs1_active_i, idk_rs2_active_i  in  1  slot k decode-stage source enables
- idk_rs1_i, idk_rs2_i  in  5  slot k decode-stage source addresses
- wmk_o  out  1  LSU-stage slot k writes a register
- amk_o  out  5  LSU-stage slot k destination
- bypass_lsuk_o  out  32  LSU-stage slot k forward data (registered ALU result)
- wwk_o  out  1  WB-stage slot k writes a register; also the regfile write enable
- awk_o  out  5  WB-stage slot k destination
- bypass_wbk_o  out  32  WB-stage slot k data; also the regfile write data
- load_use_o  out  1  decode must stall one cycle

## Operation
- **LSU stage registers, per slot:** wm, am, is_load, data.
  - Capture: wm <= exk_rd_we_i & (exk_rd_i != 0); am <= exk_rd_i; is_load <= exk_is_load_i & wm_next; data <= aluk_i.
  - x0 is never reported as written.
- **WB stage registers, per slot:** ww, aw, data.
  - Capture from the LSU stage: ww <= wm; aw <= am; data <= is_load ? lsu_rdatak_i : LSU data.
- **Update priority, per edge:**
  - rst_i: all registers are 0, asynchronously.
  - flush_i=1: LSU registers load all zeros, regardless of stall_i. WB captures normally if stall_i=0 and holds if stall_i=1. With flush and no stall, the pair already in LSU still advances to WB.
  - stall_i=1 (no flush): both stages hold.
  - Otherwise: both stages advance.
- **load_use_o** (combinational) = OR over LSU slots j with wm_j & is_load_j, and over decode sources s in {id0 rs1, id0 rs2, id1 rs1, id1 rs2}, of (s active & s addr == am_j).
  - Because am_j != 0 whenever wm_j=1, a source address of 0 never triggers.
- **Same-destination pairs:** when both slots target the same rd, both are reported unchanged. Priority (slot 1 over slot 0, LSU over WB) is resolved by the consumer.
- **Bypass data while is_load=1:** bypass_lsuk_o shows the load address (the ALU result). It is meaningless to the consumer; load_use_o guarantees it is never selected.

## Timing
- Reset: every output is 0, including load_use_o (all wm are 0 after reset).
- Latency:
  - EX inputs to LSU outputs: 1 cycle.
  - EX inputs to WB outputs: 2 cycles.
  - lsu_rdatak_i to bypass_wbk_o: 1 cycle.
- lsu_rdatak_i is sampled only on a non-stalled edge while the slot's LSU is_load=1. Otherwise it is ignored.
- load_use_o is valid in the same cycle as the LSU-stage registers and decode inputs. The decode stage responds by stalling itself and sending a bubble to EX; stall_i is not raised.
- Reset asserted mid-operation clears the pipeline immediately. Outputs return to 0 within the same cycle, with no clock edge required.

## Test plan
- **Basic advance:** ex0_rd_we=1, ex0_rd=5, alu0=0x1234 for one cycle, stall=0.
  - Next cycle: wm0=1, am0=5, bypass_lsu0=0x1234.
  - Cycle after: ww0=1, aw0=5, bypass_wb0=0x1234, wm0=0.
- **x0 suppression:** ex1_rd_we=1, ex1_rd=0, alu1=0xFFFF_FFFF → wm1 and ww1 stay 0 on every cycle.
- **Load path and hazard:** ex0 is a load, rd=7, alu0=0x100. Next cycle id1_rs2_active=1, id1_rs2=7, lsu_rdata0=0xDEAD_BEEF.
  - That cycle: load_use_o=1.
  - Following cycle: bypass_wb0=0xDEAD_BEEF, ww0=1, aw0=7.
  - With id1_rs2=8 instead, load_use_o=0.
- **Stall then flush:**
  - Pipeline holds rd=3 in LSU and rd=4 in WB. stall_i=1 for 3 cycles → outputs unchanged.
  - Then flush_i=1 with stall_i=1 → LSU zeroed, WB still rd=4.
  - Then flush_i=1 with stall_i=0 → WB gets wm=0 from the zeroed LSU; nothing new is captured.
- **Dual issue, same destination:** ex0 and ex1 both target rd=9 (alu0=1, alu1=2) → am0=am1=9, wm0=wm1=1, bypass_lsu0=1, bypass_lsu1=2. Both propagate to WB the next cycle.
- **Async reset mid-run:** assert rst_i between clock edges while the WB stage is valid → all outputs 0 immediately. Deassert → the first edge captures new EX data normally.

Source files
------------

// File: rtl/bypass_source.sv
// bypass_source: LSU/WB pipeline registers for both issue slots, feeding the EX bypass
// network and the register-file write port, plus load-use hazard detection for decode.
`default_nettype none

module bypass_source (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        ex0_rd_we_i,
   input  logic [4:0]  ex0_rd_i,
   input  logic        ex0_is_load_i,
   input  logic [31:0] alu0_i,
   input  logic [31:0] lsu_rdata0_i,
   input  logic        id0_rs1_active_i,
   input  logic        id0_rs2_active_i,
   input  logic [4:0]  id0_rs1_i,
   input  logic [4:0]  id0_rs2_i,
   input  logic        ex1_rd_we_i,
   input  logic [4:0]  ex1_rd_i,
   input  logic        ex1_is_load_i,
   input  logic [31:0] alu1_i,
   input  logic [31:0] lsu_rdata1_i,
   input  logic        id1_rs1_active_i,
   input  logic        id1_rs2_active_i,
   input  logic [4:0]  id1_rs1_i,
   input  logic [4:0]  id1_rs2_i,
   output logic        wm0_o,
   output logic [4:0]  am0_o,
   output logic [31:0] bypass_lsu0_o,
   output logic        ww0_o,
   output logic [4:0]  aw0_o,
   output logic [31:0] bypass_wb0_o,
   output logic        wm1_o,
   output logic [4:0]  am1_o,
   output logic [31:0] bypass_lsu1_o,
   output logic        ww1_o,
   output logic [4:0]  aw1_o,
   output logic [31:0] bypass_wb1_o,
   output logic        load_use_o
);

   logic [1:0]        ex_we;
   logic [1:0]        ex_load;
   logic [1:0][4:0]   ex_rd;
   logic [1:0][31:0]  alu;
   logic [1:0][31:0]  rdata;
   logic [1:0]        wm_next;

   logic [3:0]        src_active;
   logic [3:0][4:0]   src_addr;

   logic [1:0]        wm;
   logic [1:0]        is_load;
   logic [1:0][4:0]   am;
   logic [1:0][31:0]  lsu_data;
   logic [1:0]        ww;
   logic [1:0][4:0]   aw;
   logic [1:0][31:0]  wb_data;

   assign ex_we   = {ex1_rd_we_i, ex0_rd_we_i};
   assign ex_load = {ex1_is_load_i, ex0_is_load_i};
   assign ex_rd   = {ex1_rd_i, ex0_rd_i};
   assign alu     = {alu1_i, alu0_i};
   assign rdata   = {lsu_rdata1_i, lsu_rdata0_i};

   assign src_active = {id1_rs2_active_i, id1_rs1_active_i, id0_rs2_active_i, id0_rs1_active_i};
   assign src_addr   = {id1_rs2_i, id1_rs1_i, id0_rs2_i, id0_rs1_i};

   // x0 is a constant register, so a write to it is never advertised.
   always_comb begin
      wm_next = '0;
      for (int k = 0; k < 2; k++) begin
         wm_next[k] = ex_we[k] & (ex_rd[k] != 5'd0);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wm       <= '0;
         is_load  <= '0;
         am       <= '0;
         lsu_data <= '0;
         ww       <= '0;
         aw       <= '0;
         wb_data  <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            // WB reads the pre-edge LSU contents, so a flush still lets the old pair advance.
            if (!stall_i) begin
               ww[k]      <= wm[k];
               aw[k]      <= am[k];
               wb_data[k] <= is_load[k] ? rdata[k] : lsu_data[k];
            end
            if (flush_i) begin
               wm[k]       <= 1'b0;
               is_load[k]  <= 1'b0;
               am[k]       <= 5'd0;
               lsu_data[k] <= 32'd0;
            end else if (!stall_i) begin
               wm[k]       <= wm_next[k];
               is_load[k]  <= ex_load[k] & wm_next[k];
               am[k]       <= ex_rd[k];
               lsu_data[k] <= alu[k];
            end
         end
      end
   end

   // Load results are not ready until WB, so any decode source matching an LSU load must wait.
   always_comb begin
      load_use_o = 1'b0;
      for (int j = 0; j < 2; j++) begin
         for (int s = 0; s < 4; s++) begin
            if (wm[j] && is_load[j] && src_active[s] && (src_addr[s] == am[j])) begin
               load_use_o = 1'b1;
            end
         end
      end
   end

   assign wm0_o         = wm[0];
   assign am0_o         = am[0];
   assign bypass_lsu0_o = lsu_data[0];
   assign ww0_o         = ww[0];
   assign aw0_o         = aw[0];
   assign bypass_wb0_o  = wb_data[0];
   assign wm1_o         = wm[1];
   assign am1_o         = am[1];
   assign bypass_lsu1_o = lsu_data[1];
   assign ww1_o         = ww[1];
   assign aw1_o         = aw[1];
   assign bypass_wb1_o  = wb_data[1];

endmodule

`default_nettype wire

// File: tb/tb_bypass_source.sv
// tb_bypass_source: directed and randomized checks of bypass_source against an
// instruction-record reference model.
`default_nettype none

module tb_bypass_source;

   logic              clk = 1'b0;
   logic              rst, stall, flush;
   logic [1:0]        ex_we, ex_load;
   logic [1:0][4:0]   ex_rd;
   logic [1:0][31:0]  alu, rdata;
   logic [1:0]        rs1_act, rs2_act;
   logic [1:0][4:0]   rs1, rs2;

   logic [1:0]        wm, ww;
   logic [1:0][4:0]   am, aw;
   logic [1:0][31:0]  byp_lsu, byp_wb;
   logic              load_use;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        v;
      logic [4:0]  rd;
      logic        ld;
      logic [31:0] d;
   } instr_t;

   instr_t m_lsu[2];
   instr_t m_wb[2];

   always #5 clk = ~clk;

   bypass_source dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .ex0_rd_we_i(ex_we[0]), .ex0_rd_i(ex_rd[0]), .ex0_is_load_i(ex_load[0]),
      .alu0_i(alu[0]), .lsu_rdata0_i(rdata[0]),
      .id0_rs1_active_i(rs1_act[0]), .id0_rs2_active_i(rs2_act[0]),
      .id0_rs1_i(rs1[0]), .id0_rs2_i(rs2[0]),
      .ex1_rd_we_i(ex_we[1]), .ex1_rd_i(ex_rd[1]), .ex1_is_load_i(ex_load[1]),
      .alu1_i(alu[1]), .lsu_rdata1_i(rdata[1]),
      .id1_rs1_active_i(rs1_act[1]), .id1_rs2_active_i(rs2_act[1]),
      .id1_rs1_i(rs1[1]), .id1_rs2_i(rs2[1]),
      .wm0_o(wm[0]), .am0_o(am[0]), .bypass_lsu0_o(byp_lsu[0]),
      .ww0_o(ww[0]), .aw0_o(aw[0]), .bypass_wb0_o(byp_wb[0]),
      .wm1_o(wm[1]), .am1_o(am[1]), .bypass_lsu1_o(byp_lsu[1]),
      .ww1_o(ww[1]), .aw1_o(aw[1]), .bypass_wb1_o(byp_wb[1]),
      .load_use_o(load_use)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_lsu[k] = '{v: 1'b0, rd: 5'd0, ld: 1'b0, d: 32'd0};
         m_wb[k]  = '{v: 1'b0, rd: 5'd0, ld: 1'b0, d: 32'd0};
      end
   endtask

   // An instruction writes a register only if it is enabled and not aimed at x0;
   // a load's WB value is whatever the memory returned while it sat in LSU.
   task automatic model_edge();
      if (!stall) begin
         for (int k = 0; k < 2; k++) begin
            m_wb[k].v  = m_lsu[k].v;
            m_wb[k].rd = m_lsu[k].rd;
            m_wb[k].ld = 1'b0;
            m_wb[k].d  = m_lsu[k].ld ? rdata[k] : m_lsu[k].d;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (flush) begin
            m_lsu[k] = '{v: 1'b0, rd: 5'd0, ld: 1'b0, d: 32'd0};
         end else if (!stall) begin
            m_lsu[k].v  = ex_we[k] && (ex_rd[k] != 5'd0);
            m_lsu[k].rd = ex_rd[k];
            m_lsu[k].ld = ex_load[k] && ex_we[k] && (ex_rd[k] != 5'd0);
            m_lsu[k].d  = alu[k];
         end
      end
   endtask

   function automatic logic exp_load_use();
      logic hit = 1'b0;
      for (int j = 0; j < 2; j++) begin
         if (m_lsu[j].v && m_lsu[j].ld) begin
            for (int k = 0; k < 2; k++) begin
               if (rs1_act[k] && rs1[k] == m_lsu[j].rd) hit = 1'b1;
               if (rs2_act[k] && rs2[k] == m_lsu[j].rd) hit = 1'b1;
            end
         end
      end
      return hit;
   endfunction

   task automatic check_outputs(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s/wm%0d", tag, k), {31'd0, wm[k]}, {31'd0, m_lsu[k].v});
         check($sformatf("%s/am%0d", tag, k), {27'd0, am[k]}, {27'd0, m_lsu[k].rd});
         check($sformatf("%s/bypass_lsu%0d", tag, k), byp_lsu[k], m_lsu[k].d);
         check($sformatf("%s/ww%0d", tag, k), {31'd0, ww[k]}, {31'd0, m_wb[k].v});
         check($sformatf("%s/aw%0d", tag, k), {27'd0, aw[k]}, {27'd0, m_wb[k].rd});
         check($sformatf("%s/bypass_wb%0d", tag, k), byp_wb[k], m_wb[k].d);
      end
      check({tag, "/load_use"}, {31'd0, load_use}, {31'd0, exp_load_use()});
   endtask

   // Called just after a rising edge: checks the current cycle, then clocks once.
   task automatic cycle(input string tag);
      @(negedge clk);
      check_outputs(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      stall = 1'b0; flush = 1'b0;
      ex_we = '0; ex_load = '0; ex_rd = '0; alu = '0; rdata = '0;
      rs1_act = '0; rs2_act = '0; rs1 = '0; rs2 = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset();
      #3;
      check_outputs("reset");
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Basic advance
      ex_we[0] = 1'b1; ex_rd[0] = 5'd5; alu[0] = 32'h1234;
      cycle("basic_ex");
      idle_inputs();
      check("basic_lsu_am0", {27'd0, am[0]}, 32'd5);
      check("basic_lsu_data0", byp_lsu[0], 32'h1234);
      cycle("basic_lsu");
      check("basic_wb_data0", byp_wb[0], 32'h1234);
      check("basic_wb_wm0", {31'd0, wm[0]}, 32'd0);
      cycle("basic_wb");

      // x0 suppression
      ex_we[1] = 1'b1; ex_rd[1] = 5'd0; alu[1] = 32'hFFFF_FFFF;
      cycle("x0_ex");
      idle_inputs();
      check("x0_wm1", {31'd0, wm[1]}, 32'd0);
      cycle("x0_lsu");
      check("x0_ww1", {31'd0, ww[1]}, 32'd0);
      cycle("x0_wb");

      // Load path and hazard
      ex_we[0] = 1'b1; ex_rd[0] = 5'd7; ex_load[0] = 1'b1; alu[0] = 32'h100;
      cycle("ld_ex");
      idle_inputs();
      rs2_act[1] = 1'b1; rs2[1] = 5'd8; rdata[0] = 32'hDEAD_BEEF;
      #1;
      check("ld_no_hazard", {31'd0, load_use}, 32'd0);
      rs2[1] = 5'd7;
      #1;
      check("ld_hazard", {31'd0, load_use}, 32'd1);
      cycle("ld_lsu");
      idle_inputs();
      check("ld_wb_data0", byp_wb[0], 32'hDEAD_BEEF);
      check("ld_wb_aw0", {27'd0, aw[0]}, 32'd7);
      cycle("ld_wb");

      // Stall then flush
      ex_we[0] = 1'b1; ex_rd[0] = 5'd4; alu[0] = 32'h44;
      cycle("sf_ex4");
      ex_rd[0] = 5'd3; alu[0] = 32'h33;
      cycle("sf_ex3");
      idle_inputs();
      ex_we[0] = 1'b1; ex_rd[0] = 5'd12; alu[0] = 32'hBAD;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) cycle($sformatf("sf_stall%0d", i));
      check("sf_hold_am0", {27'd0, am[0]}, 32'd3);
      check("sf_hold_aw0", {27'd0, aw[0]}, 32'd4);
      flush = 1'b1;
      cycle("sf_flush_stall");
      check("sf_fs_wm0", {31'd0, wm[0]}, 32'd0);
      check("sf_fs_aw0", {27'd0, aw[0]}, 32'd4);
      stall = 1'b0;
      cycle("sf_flush");
      check("sf_f_ww0", {31'd0, ww[0]}, 32'd0);
      check("sf_f_wm0", {31'd0, wm[0]}, 32'd0);
      idle_inputs();
      cycle("sf_after");

      // Dual issue, same destination
      ex_we = 2'b11; ex_rd[0] = 5'd9; ex_rd[1] = 5'd9; alu[0] = 32'd1; alu[1] = 32'd2;
      cycle("dual_ex");
      idle_inputs();
      check("dual_am1", {27'd0, am[1]}, 32'd9);
      check("dual_lsu1", byp_lsu[1], 32'd2);
      cycle("dual_lsu");
      check("dual_wb0", byp_wb[0], 32'd1);
      check("dual_wb1", byp_wb[1], 32'd2);

      // Async reset mid-run, WB stage valid
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs("async_rst");
      rst = 1'b0;
      ex_we[0] = 1'b1; ex_rd[0] = 5'd11; alu[0] = 32'hABC;
      cycle("rst_ex");
      idle_inputs();
      check("rst_new_am0", {27'd0, am[0]}, 32'd11);
      cycle("rst_lsu");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         for (int k = 0; k < 2; k++) begin
            ex_we[k]   = ($urandom_range(0, 4) != 0);
            ex_rd[k]   = 5'($urandom_range(0, 7));
            ex_load[k] = ($urandom_range(0, 2) == 0);
            alu[k]     = $urandom;
            rdata[k]   = $urandom;
            rs1_act[k] = $urandom_range(0, 1) == 1;
            rs2_act[k] = $urandom_range(0, 1) == 1;
            rs1[k]     = 5'($urandom_range(0, 7));
            rs2[k]     = 5'($urandom_range(0, 7));
         end
         cycle($sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
